// File: rtl/keccak_padder_param.sv
// Keccak/SHA-3 multi-rate padder: packs IN_W-bit words into RATE_BITS-bit blocks and
// applies pad10*1 with a run-time domain-separation byte; back-to-back messages supported.
module keccak_padder_param #(
    parameter int RATE_BITS = 576,
    parameter int IN_W      = 64,
    parameter int BN_W      = $clog2(IN_W/8) + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [IN_W-1:0]      in,
    input  logic                 in_ready,
    input  logic                 is_last,
    input  logic [BN_W-1:0]      byte_num,
    input  logic [7:0]           dsep,
    output logic                 buffer_full,
    output logic [RATE_BITS-1:0] out,
    output logic                 out_ready,
    output logic                 out_last,
    input  logic                 f_ack
);

    localparam int WORDS = RATE_BITS / IN_W;
    localparam int IN_B  = IN_W / 8;
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    // S_PAD: data block on out, padding-only block still owed (pad_pending)
    typedef enum logic [1:0] {S_FILL, S_OUT, S_PAD} state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [7:0]           r_dsep;

    logic                 w_acc;
    logic [BN_W-1:0]      w_b;
    logic                 w_cnt_top;
    logic                 w_full_word;
    logic [RATE_BITS-1:0] w_shift;
    logic [RATE_BITS-1:0] w_aligned;
    logic [RATE_BITS-1:0] w_final;
    int                   w_k;

    // Keep the top k bytes of data, place ds at byte k (from MSB), zero the rest, set the final 0x80.
    function automatic logic [RATE_BITS-1:0] pad_block(input logic [RATE_BITS-1:0] data,
                                                       input int k,
                                                       input logic [7:0] ds);
        logic [RATE_BITS-1:0] keep;
        logic [RATE_BITS-1:0] res;
        keep      = ~({RATE_BITS{1'b1}} >> (k * 8));
        res       = (data & keep) | ({ds, {(RATE_BITS-8){1'b0}}} >> (k * 8));
        res[7:0]  = res[7:0] | 8'h80;
        return res;
    endfunction

    assign w_acc       = in_ready & ~buffer_full & (r_state == S_FILL);
    assign w_b         = (byte_num > BN_W'(IN_B)) ? BN_W'(IN_B) : byte_num;
    assign w_cnt_top   = (r_cnt == CNT_W'(WORDS - 1));
    assign w_full_word = (w_b == BN_W'(IN_B));
    assign w_shift     = {out[RATE_BITS-IN_W-1:0], in};

    // Left-justify the words received so far so byte k of the block is the pad position
    always_comb begin
        w_aligned = w_shift << ((WORDS - 1 - int'(r_cnt)) * IN_W);
        w_k       = int'(r_cnt) * IN_B + int'(w_b);
        w_final   = pad_block(w_aligned, w_k, dsep);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_FILL;
            r_cnt       <= '0;
            r_dsep      <= '0;
            out         <= '0;
            out_ready   <= 1'b0;
            out_last    <= 1'b0;
            buffer_full <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_acc) begin
                        if (is_last && w_full_word && w_cnt_top) begin
                            out         <= w_shift;
                            out_ready   <= 1'b1;
                            out_last    <= 1'b0;
                            buffer_full <= 1'b1;
                            r_dsep      <= dsep;
                            r_cnt       <= '0;
                            r_state     <= S_PAD;
                        end else if (is_last) begin
                            out         <= w_final;
                            out_ready   <= 1'b1;
                            out_last    <= 1'b1;
                            buffer_full <= 1'b1;
                            r_cnt       <= '0;
                            r_state     <= S_OUT;
                        end else if (w_cnt_top) begin
                            out         <= w_shift;
                            out_ready   <= 1'b1;
                            out_last    <= 1'b0;
                            buffer_full <= 1'b1;
                            r_cnt       <= '0;
                            r_state     <= S_OUT;
                        end else begin
                            out   <= w_shift;
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_OUT: begin
                    if (f_ack) begin
                        out_ready   <= 1'b0;
                        out_last    <= 1'b0;
                        buffer_full <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= S_FILL;
                    end
                end
                S_PAD: begin
                    if (f_ack) begin
                        out         <= pad_block('0, 0, r_dsep);
                        out_ready   <= 1'b1;
                        out_last    <= 1'b1;
                        buffer_full <= 1'b1;
                        r_state     <= S_OUT;
                    end
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_padder_param.sv
// Directed bench for keccak_padder_param: a 576-bit instance and a 1088-bit instance.
module tb_keccak_padder_param;

    localparam logic [63:0] W = 64'h1234567890ABCDEF;

    logic          clk = 1'b0;
    logic          reset_n, reset_n2;
    logic [63:0]   in_d;
    logic          in_ready, in_ready2;
    logic          is_last;
    logic [3:0]    byte_num;
    logic [7:0]    dsep;
    logic          f_ack, f_ack2;

    logic          buffer_full, out_ready, out_last;
    logic [575:0]  out_blk;
    logic          buffer_full2, out_ready2, out_last2;
    logic [1087:0] out_blk2;

    int n_checks = 0;
    int n_errors = 0;

    keccak_padder_param #(.RATE_BITS(576), .IN_W(64)) u_dut (
        .clk(clk), .reset_n(reset_n), .in(in_d), .in_ready(in_ready), .is_last(is_last),
        .byte_num(byte_num), .dsep(dsep), .buffer_full(buffer_full), .out(out_blk),
        .out_ready(out_ready), .out_last(out_last), .f_ack(f_ack));

    keccak_padder_param #(.RATE_BITS(1088), .IN_W(64)) u_dut2 (
        .clk(clk), .reset_n(reset_n2), .in(in_d), .in_ready(in_ready2), .is_last(is_last),
        .byte_num(byte_num), .dsep(dsep), .buffer_full(buffer_full2), .out(out_blk2),
        .out_ready(out_ready2), .out_last(out_last2), .f_ack(f_ack2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_blk(input string tag, input logic [1087:0] got,
                           input logic [1087:0] exp, input int nw);
        for (int i = 0; i < nw; i++)
            chk($sformatf("%s[%0d]", tag, i), got[(nw-1-i)*64 +: 64], exp[(nw-1-i)*64 +: 64]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send1(input logic [63:0] w, input logic last, input logic [3:0] b,
                         input logic [7:0] ds);
        in_d = w; is_last = last; byte_num = b; dsep = ds; in_ready = 1'b1;
        tick();
        in_ready = 1'b0; is_last = 1'b0;
    endtask

    task automatic send2(input logic [63:0] w, input logic last, input logic [3:0] b,
                         input logic [7:0] ds);
        in_d = w; is_last = last; byte_num = b; dsep = ds; in_ready2 = 1'b1;
        tick();
        in_ready2 = 1'b0; is_last = 1'b0;
    endtask

    task automatic ack1();
        f_ack = 1'b1;
        tick();
        f_ack = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; reset_n2 = 1'b0;
        in_d = '0; in_ready = 1'b0; in_ready2 = 1'b0; is_last = 1'b0;
        byte_num = '0; dsep = '0; f_ack = 1'b0; f_ack2 = 1'b0;
        tick(); tick();
        chk("rst_ready", 64'(out_ready), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_bfull", 64'(buffer_full), 64'd0);
        chk_blk("rst_out", 1088'(out_blk), 1088'd0, 9);
        reset_n = 1'b1; reset_n2 = 1'b1;

        // 1: empty message after idle, held is_last not eaten twice
        repeat (7) tick();
        in_d = W; is_last = 1'b1; byte_num = 4'd0; dsep = 8'h01; in_ready = 1'b1;
        tick();
        chk("t1_ready", 64'(out_ready), 64'd1);
        chk("t1_last", 64'(out_last), 64'd1);
        chk("t1_bfull", 64'(buffer_full), 64'd1);
        chk_blk("t1_blk", 1088'(out_blk), 1088'({8'h01, 560'h0, 8'h80}), 9);
        tick();
        chk_blk("t1_hold", 1088'(out_blk), 1088'({8'h01, 560'h0, 8'h80}), 9);
        chk("t1_hold_ready", 64'(out_ready), 64'd1);
        in_ready = 1'b0; is_last = 1'b0;
        ack1();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t1_bf_idle%0d", i), 64'(buffer_full), 64'd0);
            chk($sformatf("t1_rdy_idle%0d", i), 64'(out_ready), 64'd0);
            tick();
        end

        // 2: partial last word b=7, then b=0
        for (int i = 0; i < 8; i++) send1(W, 1'b0, 4'd0, 8'h00);
        chk("t2_notyet", 64'(out_ready), 64'd0);
        send1(W, 1'b1, 4'd7, 8'h01);
        chk("t2a_ready", 64'(out_ready), 64'd1);
        chk("t2a_last", 64'(out_last), 64'd1);
        chk_blk("t2a_blk", 1088'(out_blk), 1088'({{8{W}}, 64'h1234567890ABCD81}), 9);
        ack1();
        for (int i = 0; i < 8; i++) send1(W, 1'b0, 4'd0, 8'h00);
        send1(W, 1'b1, 4'd0, 8'h01);
        chk_blk("t2b_blk", 1088'(out_blk), 1088'({{8{W}}, 64'h0100000000000080}), 9);
        chk("t2b_last", 64'(out_last), 64'd1);
        ack1();

        // 3: full non-last block, back-pressure, then b=6
        for (int i = 0; i < 9; i++) send1(W, 1'b0, 4'd0, 8'h00);
        chk("t3_ready", 64'(out_ready), 64'd1);
        chk("t3_last", 64'(out_last), 64'd0);
        chk_blk("t3_blk", 1088'(out_blk), 1088'({9{W}}), 9);
        in_d = 64'h999; in_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("t3_bf%0d", i), 64'(buffer_full), 64'd1);
            chk($sformatf("t3_stable%0d", i), out_blk[63:0], W);
        end
        in_ready = 1'b0;
        ack1();
        chk("t3_ack_ready", 64'(out_ready), 64'd0);
        for (int i = 0; i < 8; i++) send1(W, 1'b0, 4'd0, 8'h00);
        send1(W, 1'b1, 4'd6, 8'h01);
        chk_blk("t3b_blk", 1088'(out_blk), 1088'({{8{W}}, 64'h1234567890AB0180}), 9);
        chk("t3b_last", 64'(out_last), 64'd1);
        ack1();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t3_idle%0d", i), 64'(out_ready), 64'd0);
            tick();
        end

        // 4: message ends on block boundary -> extra padding block
        for (int i = 0; i < 8; i++) send1(W, 1'b0, 4'd0, 8'h00);
        send1(W, 1'b1, 4'd8, 8'h01);
        chk("t4_ready", 64'(out_ready), 64'd1);
        chk("t4_last", 64'(out_last), 64'd0);
        chk("t4_bfull", 64'(buffer_full), 64'd1);
        chk_blk("t4_blk", 1088'(out_blk), 1088'({9{W}}), 9);
        in_d = 64'h999; in_ready = 1'b1;
        tick();
        chk("t4_noeat", out_blk[63:0], W);
        f_ack = 1'b1;
        tick();
        f_ack = 1'b0;
        chk("t4_pad_ready", 64'(out_ready), 64'd1);
        chk("t4_pad_last", 64'(out_last), 64'd1);
        chk_blk("t4_pad_blk", 1088'(out_blk), 1088'({8'h01, 560'h0, 8'h80}), 9);
        in_ready = 1'b0;
        ack1();
        chk("t4_done_ready", 64'(out_ready), 64'd0);
        chk("t4_done_bfull", 64'(buffer_full), 64'd0);

        // 5: back-to-back messages with different dsep
        send1(W, 1'b1, 4'd8, 8'h06);
        chk_blk("t5a_blk", 1088'(out_blk), 1088'({W, 8'h06, 496'h0, 8'h80}), 9);
        chk("t5a_last", 64'(out_last), 64'd1);
        ack1();
        send1(64'h0, 1'b1, 4'd0, 8'h1F);
        chk_blk("t5b_blk", 1088'(out_blk), 1088'({8'h1F, 560'h0, 8'h80}), 9);
        ack1();

        // 6: 1088-bit rate, then async reset mid-block
        send2(64'h0, 1'b1, 4'd0, 8'h1F);
        chk("t6_ready", 64'(out_ready2), 64'd1);
        chk("t6_last", 64'(out_last2), 64'd1);
        chk_blk("t6_blk", out_blk2, {8'h1F, 1072'h0, 8'h80}, 17);
        f_ack2 = 1'b1; tick(); f_ack2 = 1'b0;
        chk("t6_ack_ready", 64'(out_ready2), 64'd0);
        for (int i = 0; i < 3; i++) send2(W, 1'b0, 4'd0, 8'h00);
        chk("t6_filled", out_blk2[63:0], W);
        #2;
        reset_n2 = 1'b0;
        #1;
        chk_blk("t6_rst_out", out_blk2, 1088'd0, 17);
        chk("t6_rst_ready", 64'(out_ready2), 64'd0);
        chk("t6_rst_last", 64'(out_last2), 64'd0);
        chk("t6_rst_bfull", 64'(buffer_full2), 64'd0);
        tick();
        reset_n2 = 1'b1;
        tick();
        send2(W, 1'b1, 4'd8, 8'h1F);
        chk_blk("t6_after_rst", out_blk2, {W, 8'h1F, 1008'h0, 8'h80}, 17);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
